// File: rtl/sub_bytes_seq.sv
// sub_bytes_seq: sequential AES forward SubBytes over a 128-bit state,
// started by a start/done handshake.
// Optional build macro SUB_BYTES_WORD_EN: four S-box lanes, 32 bits per step.
// Without it the unit has one S-box lane and handles 8 bits per step.
module sub_bytes_seq (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] s_in,
    output logic         busy,
    output logic         done,
    output logic [127:0] s_o
);

`ifdef SUB_BYTES_WORD_EN
    localparam int unsigned STEP_W   = 32;
    localparam int unsigned LAST_CNT = 3;
`else
    localparam int unsigned STEP_W   = 8;
    localparam int unsigned LAST_CNT = 15;
`endif
    localparam int unsigned NLANE = STEP_W / 8;
    localparam int unsigned CNT_W = 5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SUB  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e             state_q;
    logic [127:0]       temp_q;
    logic [127:0]       acc_q;
    logic [CNT_W-1:0]   bytecnt_q;
    logic [127:0]       s_o_q;
    logic               busy_q;
    logic               done_q;

    logic [STEP_W-1:0]  sub_c;
    logic [127:0]       temp_d;
    logic [127:0]       acc_d;

    // FIPS-197 forward S-box as a case ROM
    function automatic logic [7:0] sbox_f(input logic [7:0] a);
        logic [7:0] s;
        s = 8'h00;
        case (a)
            8'h00: s = 8'h63; 8'h01: s = 8'h7c; 8'h02: s = 8'h77; 8'h03: s = 8'h7b; 8'h04: s = 8'hf2; 8'h05: s = 8'h6b; 8'h06: s = 8'h6f; 8'h07: s = 8'hc5;
            8'h08: s = 8'h30; 8'h09: s = 8'h01; 8'h0a: s = 8'h67; 8'h0b: s = 8'h2b; 8'h0c: s = 8'hfe; 8'h0d: s = 8'hd7; 8'h0e: s = 8'hab; 8'h0f: s = 8'h76;
            8'h10: s = 8'hca; 8'h11: s = 8'h82; 8'h12: s = 8'hc9; 8'h13: s = 8'h7d; 8'h14: s = 8'hfa; 8'h15: s = 8'h59; 8'h16: s = 8'h47; 8'h17: s = 8'hf0;
            8'h18: s = 8'had; 8'h19: s = 8'hd4; 8'h1a: s = 8'ha2; 8'h1b: s = 8'haf; 8'h1c: s = 8'h9c; 8'h1d: s = 8'ha4; 8'h1e: s = 8'h72; 8'h1f: s = 8'hc0;
            8'h20: s = 8'hb7; 8'h21: s = 8'hfd; 8'h22: s = 8'h93; 8'h23: s = 8'h26; 8'h24: s = 8'h36; 8'h25: s = 8'h3f; 8'h26: s = 8'hf7; 8'h27: s = 8'hcc;
            8'h28: s = 8'h34; 8'h29: s = 8'ha5; 8'h2a: s = 8'he5; 8'h2b: s = 8'hf1; 8'h2c: s = 8'h71; 8'h2d: s = 8'hd8; 8'h2e: s = 8'h31; 8'h2f: s = 8'h15;
            8'h30: s = 8'h04; 8'h31: s = 8'hc7; 8'h32: s = 8'h23; 8'h33: s = 8'hc3; 8'h34: s = 8'h18; 8'h35: s = 8'h96; 8'h36: s = 8'h05; 8'h37: s = 8'h9a;
            8'h38: s = 8'h07; 8'h39: s = 8'h12; 8'h3a: s = 8'h80; 8'h3b: s = 8'he2; 8'h3c: s = 8'heb; 8'h3d: s = 8'h27; 8'h3e: s = 8'hb2; 8'h3f: s = 8'h75;
            8'h40: s = 8'h09; 8'h41: s = 8'h83; 8'h42: s = 8'h2c; 8'h43: s = 8'h1a; 8'h44: s = 8'h1b; 8'h45: s = 8'h6e; 8'h46: s = 8'h5a; 8'h47: s = 8'ha0;
            8'h48: s = 8'h52; 8'h49: s = 8'h3b; 8'h4a: s = 8'hd6; 8'h4b: s = 8'hb3; 8'h4c: s = 8'h29; 8'h4d: s = 8'he3; 8'h4e: s = 8'h2f; 8'h4f: s = 8'h84;
            8'h50: s = 8'h53; 8'h51: s = 8'hd1; 8'h52: s = 8'h00; 8'h53: s = 8'hed; 8'h54: s = 8'h20; 8'h55: s = 8'hfc; 8'h56: s = 8'hb1; 8'h57: s = 8'h5b;
            8'h58: s = 8'h6a; 8'h59: s = 8'hcb; 8'h5a: s = 8'hbe; 8'h5b: s = 8'h39; 8'h5c: s = 8'h4a; 8'h5d: s = 8'h4c; 8'h5e: s = 8'h58; 8'h5f: s = 8'hcf;
            8'h60: s = 8'hd0; 8'h61: s = 8'hef; 8'h62: s = 8'haa; 8'h63: s = 8'hfb; 8'h64: s = 8'h43; 8'h65: s = 8'h4d; 8'h66: s = 8'h33; 8'h67: s = 8'h85;
            8'h68: s = 8'h45; 8'h69: s = 8'hf9; 8'h6a: s = 8'h02; 8'h6b: s = 8'h7f; 8'h6c: s = 8'h50; 8'h6d: s = 8'h3c; 8'h6e: s = 8'h9f; 8'h6f: s = 8'ha8;
            8'h70: s = 8'h51; 8'h71: s = 8'ha3; 8'h72: s = 8'h40; 8'h73: s = 8'h8f; 8'h74: s = 8'h92; 8'h75: s = 8'h9d; 8'h76: s = 8'h38; 8'h77: s = 8'hf5;
            8'h78: s = 8'hbc; 8'h79: s = 8'hb6; 8'h7a: s = 8'hda; 8'h7b: s = 8'h21; 8'h7c: s = 8'h10; 8'h7d: s = 8'hff; 8'h7e: s = 8'hf3; 8'h7f: s = 8'hd2;
            8'h80: s = 8'hcd; 8'h81: s = 8'h0c; 8'h82: s = 8'h13; 8'h83: s = 8'hec; 8'h84: s = 8'h5f; 8'h85: s = 8'h97; 8'h86: s = 8'h44; 8'h87: s = 8'h17;
            8'h88: s = 8'hc4; 8'h89: s = 8'ha7; 8'h8a: s = 8'h7e; 8'h8b: s = 8'h3d; 8'h8c: s = 8'h64; 8'h8d: s = 8'h5d; 8'h8e: s = 8'h19; 8'h8f: s = 8'h73;
            8'h90: s = 8'h60; 8'h91: s = 8'h81; 8'h92: s = 8'h4f; 8'h93: s = 8'hdc; 8'h94: s = 8'h22; 8'h95: s = 8'h2a; 8'h96: s = 8'h90; 8'h97: s = 8'h88;
            8'h98: s = 8'h46; 8'h99: s = 8'hee; 8'h9a: s = 8'hb8; 8'h9b: s = 8'h14; 8'h9c: s = 8'hde; 8'h9d: s = 8'h5e; 8'h9e: s = 8'h0b; 8'h9f: s = 8'hdb;
            8'ha0: s = 8'he0; 8'ha1: s = 8'h32; 8'ha2: s = 8'h3a; 8'ha3: s = 8'h0a; 8'ha4: s = 8'h49; 8'ha5: s = 8'h06; 8'ha6: s = 8'h24; 8'ha7: s = 8'h5c;
            8'ha8: s = 8'hc2; 8'ha9: s = 8'hd3; 8'haa: s = 8'hac; 8'hab: s = 8'h62; 8'hac: s = 8'h91; 8'had: s = 8'h95; 8'hae: s = 8'he4; 8'haf: s = 8'h79;
            8'hb0: s = 8'he7; 8'hb1: s = 8'hc8; 8'hb2: s = 8'h37; 8'hb3: s = 8'h6d; 8'hb4: s = 8'h8d; 8'hb5: s = 8'hd5; 8'hb6: s = 8'h4e; 8'hb7: s = 8'ha9;
            8'hb8: s = 8'h6c; 8'hb9: s = 8'h56; 8'hba: s = 8'hf4; 8'hbb: s = 8'hea; 8'hbc: s = 8'h65; 8'hbd: s = 8'h7a; 8'hbe: s = 8'hae; 8'hbf: s = 8'h08;
            8'hc0: s = 8'hba; 8'hc1: s = 8'h78; 8'hc2: s = 8'h25; 8'hc3: s = 8'h2e; 8'hc4: s = 8'h1c; 8'hc5: s = 8'ha6; 8'hc6: s = 8'hb4; 8'hc7: s = 8'hc6;
            8'hc8: s = 8'he8; 8'hc9: s = 8'hdd; 8'hca: s = 8'h74; 8'hcb: s = 8'h1f; 8'hcc: s = 8'h4b; 8'hcd: s = 8'hbd; 8'hce: s = 8'h8b; 8'hcf: s = 8'h8a;
            8'hd0: s = 8'h70; 8'hd1: s = 8'h3e; 8'hd2: s = 8'hb5; 8'hd3: s = 8'h66; 8'hd4: s = 8'h48; 8'hd5: s = 8'h03; 8'hd6: s = 8'hf6; 8'hd7: s = 8'h0e;
            8'hd8: s = 8'h61; 8'hd9: s = 8'h35; 8'hda: s = 8'h57; 8'hdb: s = 8'hb9; 8'hdc: s = 8'h86; 8'hdd: s = 8'hc1; 8'hde: s = 8'h1d; 8'hdf: s = 8'h9e;
            8'he0: s = 8'he1; 8'he1: s = 8'hf8; 8'he2: s = 8'h98; 8'he3: s = 8'h11; 8'he4: s = 8'h69; 8'he5: s = 8'hd9; 8'he6: s = 8'h8e; 8'he7: s = 8'h94;
            8'he8: s = 8'h9b; 8'he9: s = 8'h1e; 8'hea: s = 8'h87; 8'heb: s = 8'he9; 8'hec: s = 8'hce; 8'hed: s = 8'h55; 8'hee: s = 8'h28; 8'hef: s = 8'hdf;
            8'hf0: s = 8'h8c; 8'hf1: s = 8'ha1; 8'hf2: s = 8'h89; 8'hf3: s = 8'h0d; 8'hf4: s = 8'hbf; 8'hf5: s = 8'he6; 8'hf6: s = 8'h42; 8'hf7: s = 8'h68;
            8'hf8: s = 8'h41; 8'hf9: s = 8'h99; 8'hfa: s = 8'h2d; 8'hfb: s = 8'h0f; 8'hfc: s = 8'hb0; 8'hfd: s = 8'h54; 8'hfe: s = 8'hbb; 8'hff: s = 8'h16;
        endcase
        return s;
    endfunction

    // S-box lanes on the low end of the working copy
    for (genvar b = 0; b < NLANE; b++) begin : g_lane
        assign sub_c[8*b +: 8] = sbox_f(temp_q[8*b +: 8]);
    end

    // One step: consume the low lane of temp, push its substitution in at the top of acc
    assign temp_d = temp_q >> STEP_W;
    assign acc_d  = {sub_c, acc_q[127:STEP_W]};

    // Control FSM with registered busy/done/s_o; DONE accepts start like IDLE
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            temp_q    <= 128'd0;
            acc_q     <= 128'd0;
            bytecnt_q <= CNT_W'(0);
            s_o_q     <= 128'd0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    busy_q <= 1'b0;
                    if (start) begin
                        temp_q    <= s_in;
                        bytecnt_q <= CNT_W'(0);
                        busy_q    <= 1'b1;
                        state_q   <= ST_SUB;
                    end else begin
                        state_q   <= ST_IDLE;
                    end
                end
                ST_SUB: begin
                    temp_q <= temp_d;
                    acc_q  <= acc_d;
                    if (bytecnt_q == CNT_W'(LAST_CNT)) begin
                        s_o_q   <= acc_d;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= ST_DONE;
                    end else begin
                        bytecnt_q <= bytecnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign s_o  = s_o_q;

endmodule

// File: tb/tb_sub_bytes_seq.sv
// Self-checking bench for sub_bytes_seq; expected states come from an
// arithmetic S-box model (GF(2^8) inverse plus affine map) and known constants.
module tb_sub_bytes_seq;

`ifdef SUB_BYTES_WORD_EN
    localparam int LAT   = 4;
    localparam int IGN_A = 2;
    localparam int IGN_B = 3;
    localparam int RST_AT = 2;
`else
    localparam int LAT   = 16;
    localparam int IGN_A = 3;
    localparam int IGN_B = 10;
    localparam int RST_AT = 8;
`endif

    logic         clk;
    logic         rst;
    logic         start;
    logic [127:0] s_in;
    logic         busy;
    logic         done;
    logic [127:0] s_o;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int done_cnt    = 0;
    int last_done   = 0;

    logic [127:0] exp_q[$];
    int           acc_cyc_q[$];

    sub_bytes_seq dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .s_in  (s_in),
        .busy  (busy),
        .done  (done),
        .s_o   (s_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
        logic [15:0] t;
        t = {b, b} << n;
        return t[15:8];
    endfunction

    function automatic logic [7:0] model_sbox(input logic [7:0] a);
        logic [7:0] inv;
        inv = 8'h00;
        if (a != 8'h00) begin
            for (int x = 1; x < 256; x++) begin
                if (gmul(a, 8'(x)) == 8'h01) inv = 8'(x);
            end
        end
        return inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
    endfunction

    function automatic logic [127:0] model_state(input logic [127:0] x);
        logic [127:0] r;
        r = 128'd0;
        for (int i = 0; i < 16; i++) r[8*i +: 8] = model_sbox(x[8*i +: 8]);
        return r;
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every done pops one expected state and its acceptance cycle
    always @(negedge clk) begin
        if (rst === 1'b1 && done === 1'b1) begin
            vectors++;
            assert (exp_q.size() != 0) else begin
                miscompares++;
                $error("FAIL unexpected_done: observed done at cycle %0d expected none", cyc);
            end
            if (exp_q.size() != 0) begin
                check("s_o", s_o, exp_q.pop_front());
                check("latency", 128'(cyc - acc_cyc_q.pop_front()), 128'(LAT));
            end
            check("busy_with_done", 128'(busy), 128'd0);
            last_done = cyc;
            done_cnt++;
        end
    end

    // Drive one block at the current negedge; acceptance edge is the next posedge
    task automatic launch(input logic [127:0] data, input bit hold);
        s_in  = data;
        start = 1'b1;
        exp_q.push_back(model_state(data));
        acc_cyc_q.push_back(cyc + 1);
        @(negedge clk);
        if (!hold) start = 1'b0;
    endtask

    task automatic wait_dones(input int target);
        int n;
        n = 0;
        while (done_cnt < target && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("done_count", 128'(done_cnt), 128'(target));
    endtask

    logic [127:0] kv;
    logic [127:0] b2;
    int           first_done;
    int           n;

    initial begin
        kv    = 128'h00112233445566778899aabbccddeeff;
        rst   = 1'b0;
        start = 1'b0;
        s_in  = 128'd0;

        // Reset held with random inputs
        repeat (4) begin
            @(negedge clk);
            start = 1'(($urandom % 2));
            s_in  = {$urandom, $urandom, $urandom, $urandom};
            check("rst_hold_done", 128'(done), 128'd0);
        end
        start = 1'b0;
        rst   = 1'b1;
        #1;
        check("rst_s_o", s_o, 128'd0);
        check("rst_busy", 128'(busy), 128'd0);
        check("rst_done", 128'(done), 128'd0);
        repeat (6) @(negedge clk);
        check("idle_no_done", 128'(done_cnt), 128'd0);

        // Known vector
        launch(kv, 1'b0);
        check("busy_after_accept", 128'(busy), 128'd1);
        wait_dones(1);
        @(negedge clk);
        check("kv_literal", s_o, 128'h638293c31bfc33f5c4eeacea4bc12816);
        check("s_o_held", s_o, 128'h638293c31bfc33f5c4eeacea4bc12816);

        // Edge bytes
        launch({16{8'h00}}, 1'b0);
        wait_dones(2);
        @(negedge clk);
        check("all00", s_o, {16{8'h63}});
        launch({16{8'hff}}, 1'b0);
        wait_dones(3);
        @(negedge clk);
        check("allff", s_o, {16{8'h16}});
        launch({16{8'h53}}, 1'b0);
        wait_dones(4);
        @(negedge clk);
        check("all53", s_o, {16{8'hed}});

        // Start pulses during busy are ignored
        launch(128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0, 1'b0);
        n = 1;
        while (n < IGN_B + 1) begin
            if (n == IGN_A || n == IGN_B) begin
                s_in  = {$urandom, $urandom, $urandom, $urandom};
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        wait_dones(5);
        repeat (LAT + 6) @(negedge clk);
        check("one_done_only", 128'(done_cnt), 128'd5);
        check("idle_busy", 128'(busy), 128'd0);

        // Back-to-back with start held; second block accepted in the DONE cycle
        b2 = 128'hdeadbeef0123456789abcdeffedcba98;
        launch(128'h3243f6a8885a308d313198a2e0370734, 1'b1);
        n = 0;
        while (done !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        first_done = cyc;
        s_in = b2;
        exp_q.push_back(model_state(b2));
        acc_cyc_q.push_back(cyc + 1);
        @(negedge clk);
        check("b2b_busy", 128'(busy), 128'd1);
        start = 1'b0;
        wait_dones(7);
        check("b2b_spacing", 128'(last_done - first_done), 128'(LAT + 1));
        @(negedge clk);
        check("b2b_second", s_o, model_state(b2));

        // Reset in the middle of a block
        launch(128'h00000000000000000000000000000001, 1'b0);
        repeat (RST_AT - 1) @(negedge clk);
        #2;
        rst = 1'b0;
        exp_q.delete();
        acc_cyc_q.delete();
        #1;
        check("midrst_busy", 128'(busy), 128'd0);
        check("midrst_s_o", s_o, 128'd0);
        check("midrst_done", 128'(done), 128'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (LAT + 6) @(negedge clk);
        check("midrst_no_done", 128'(done_cnt), 128'd7);
        launch(kv, 1'b0);
        wait_dones(8);
        @(negedge clk);
        check("after_rst_kv", s_o, 128'h638293c31bfc33f5c4eeacea4bc12816);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
